// File: rtl/irq_controller.sv
// External interrupt controller feeding processor_arm's ExtIRQ input.
// Rising edges on irq_src are latched into a pending register. Pending bits are
// qualified by a mask, and the lowest-index active source is presented on irq_id.
// A source is retired on the processor's ExtIAck.
// The mask and write-1-to-clear registers are written by snooping the data-memory
// store bus.
// Optional macro IRQ_SYNC_EN: when defined, a 2-flop synchronizer sits in front of
// the edge detector.
module irq_controller #(
  parameter int unsigned     NSRC      = 4,
  parameter int unsigned     IDW       = 2,
  parameter int unsigned     N         = 64,
  parameter logic [N-1:0]    MASK_ADDR = 64'h400,
  parameter logic [N-1:0]    CLR_ADDR  = 64'h408
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [NSRC-1:0]  irq_src,
  input  logic [N-1:0]     DM_addr,
  input  logic [N-1:0]     DM_writeData,
  input  logic             DM_writeEnable,
  input  logic             ExtIAck,
  output logic             ExtIRQ,
  output logic [IDW-1:0]   irq_id,
  output logic [NSRC-1:0]  irq_pending
);

  typedef enum logic [1:0] {StIdle, StReq, StAck} state_e;

  state_e          state_q;
  logic [NSRC-1:0] src_in;
  logic [NSRC-1:0] src_prev_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] src_event;
  logic [NSRC-1:0] store_clr;
  logic [NSRC-1:0] ack_clr;
  logic [NSRC-1:0] active;
  logic            mask_we;
  logic            clr_we;

  // Upper store-data bits have no register behind them.
  logic unused_data;
  assign unused_data = ^DM_writeData[N-1:NSRC];

  // Lowest set index wins.
  function automatic logic [IDW-1:0] prio(input logic [NSRC-1:0] v);
    prio = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) prio = IDW'(i);
    end
  endfunction

`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for asynchronous peripheral lines.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_in = sync2_q;
`else
  assign src_in = irq_src;
`endif

  assign mask_we = DM_writeEnable && (DM_addr == MASK_ADDR);
  assign clr_we  = DM_writeEnable && (DM_addr == CLR_ADDR);
  assign active  = pending_q & mask_q;

  // Edge detect and pending next-state; a new event beats any clear.
  always_comb begin
    src_event = src_in & ~src_prev_q;
    store_clr = clr_we ? DM_writeData[NSRC-1:0] : '0;
    ack_clr   = '0;
    if (state_q == StReq && ExtIAck) begin
      for (int i = 0; i < NSRC; i++) begin
        ack_clr[i] = (irq_id == IDW'(i));
      end
    end
    pending_d = (pending_q & ~(store_clr | ack_clr)) | src_event;
  end

  // Source history, pending and mask registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      src_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
    end else begin
      src_prev_q <= src_in;
      pending_q  <= pending_d;
      if (mask_we) mask_q <= DM_writeData[NSRC-1:0];
    end
  end

  // Request/acknowledge handshake with registered ExtIRQ and irq_id.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ExtIRQ  <= 1'b0;
      irq_id  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (active != '0) begin
            state_q <= StReq;
            ExtIRQ  <= 1'b1;
            irq_id  <= prio(active);
          end
        end
        StReq: begin
          if (ExtIAck) begin
            state_q <= StAck;
            ExtIRQ  <= 1'b0;
          end else if (active == '0) begin
            state_q <= StIdle;
            ExtIRQ  <= 1'b0;
          end else begin
            // Re-evaluate so a higher-priority arrival preempts before ack.
            irq_id <= prio(active);
          end
        end
        StAck: begin
          // Hold until the ack pulse ends so one pulse retires one source.
          if (!ExtIAck) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          ExtIRQ  <= 1'b0;
        end
      endcase
    end
  end

  assign irq_pending = pending_q;

endmodule
